// File: rtl/alu_req_driver.sv
// alu_req_driver: issue side of the ALU operand interface.
// Commands {a,b,op} are registered onto the ALU inputs. The combinational ALU
// result is captured one cycle later into an in-order result buffer. The
// buffer is drained on a valid/ready response stream.
// Optional checker: define ALU_REQ_CHECK_EN to enable the internal reference
// model that flags ALU result mismatches on err / mismatch_cnt.
module alu_req_driver #(
   parameter int unsigned N     = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [N-1:0] cmd_a,
   input  logic [N-1:0] cmd_b,
   input  logic [2:0]   cmd_op,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [2:0]   alu_op,
   input  logic [N-1:0] alu_y,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_y,
   output logic [2:0]   rsp_op,
   output logic         err,
   output logic [7:0]   mismatch_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);

   // ALU operand registers and in-flight flag
   logic [N-1:0] r_alu_a;
   logic [N-1:0] r_alu_b;
   logic [2:0]   r_alu_op;
   logic         r_inflight;

   // result buffer storage and pointers
   logic [N-1:0] r_mem_y  [DEPTH];
   logic [2:0]   r_mem_op [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   // handshake and occupancy wires
   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic [AW+1:0] w_occ;

   // occupancy counts the in-flight command so a full buffer can never be overrun
   always_comb begin
      w_occ     = {1'b0, r_count} + (AW+2)'(r_inflight);
      cmd_ready = (w_occ < (AW+2)'(DEPTH));
      rsp_valid = (r_count != '0);
      w_accept  = cmd_valid && cmd_ready;
      w_push    = r_inflight;
      w_pop     = rsp_valid && rsp_ready;
   end

   assign alu_a  = r_alu_a;
   assign alu_b  = r_alu_b;
   assign alu_op = r_alu_op;
   assign rsp_y  = r_mem_y[r_rptr];
   assign rsp_op = r_mem_op[r_rptr];

   // operand registers load on accept and hold otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
      end else if (w_accept) begin
         r_alu_a  <= cmd_a;
         r_alu_b  <= cmd_b;
         r_alu_op <= cmd_op;
      end
   end

   // in-flight is set by an accept and cleared by the capture that follows
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_accept;
      end
   end

   // capture the ALU result with the opcode that produced it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem_y[i]  <= '0;
            r_mem_op[i] <= '0;
         end
      end else if (w_push) begin
         r_mem_y[r_wptr]  <= alu_y;
         r_mem_op[r_wptr] <= r_alu_op;
      end
   end

   // buffer pointers wrap modulo DEPTH; count is unchanged on push+pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef ALU_REQ_CHECK_EN
   logic [N-1:0] w_exp;
   logic         w_mismatch;
   logic         r_err;
   logic [7:0]   r_mis_cnt;

   // reference ALU evaluated on the operands currently presented to the ALU
   always_comb begin
      w_exp = '0;
      unique case (r_alu_op)
         3'b000: w_exp = r_alu_a + r_alu_b;
         3'b001: w_exp = r_alu_a - r_alu_b;
         3'b010: w_exp = r_alu_a & r_alu_b;
         3'b011: w_exp = r_alu_a | r_alu_b;
         3'b100: w_exp = r_alu_a ^ r_alu_b;
         3'b101: w_exp = r_alu_a << 1;
         3'b110: w_exp = r_alu_a >> 1;
         default: w_exp = r_alu_a;
      endcase
      w_mismatch = r_inflight && (alu_y != w_exp);
   end

   // sticky error flag and saturating mismatch counter, updated on capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err     <= 1'b0;
         r_mis_cnt <= '0;
      end else if (w_mismatch) begin
         r_err <= 1'b1;
         if (r_mis_cnt != '1) begin
            r_mis_cnt <= r_mis_cnt + 8'd1;
         end
      end
   end

   assign err          = r_err;
   assign mismatch_cnt = r_mis_cnt;
`else
   assign err          = 1'b0;
   assign mismatch_cnt = '0;
`endif

endmodule
